// File: rtl/alarm_time_sequencer.sv
// alarm_time_sequencer
// Keeps BCD hh:mm plus binary seconds, advanced by a 1 Hz tick or overwritten
// by a CPU load, and pushes each new hh:mm to the hours/minutes 7-segment
// output ports as two Avalon-MM writes. The hours/minutes pair is snapshotted
// when a sequence starts, so the display never sees a torn pair.
module alarm_time_sequencer #(
  parameter bit SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick_1hz,
  input  logic        load,
  input  logic [7:0]  load_hours,
  input  logic [7:0]  load_minutes,
  output logic [7:0]  time_hours,
  output logic [7:0]  time_minutes,
  output logic [5:0]  time_seconds,
  output logic        busy,
  output logic [1:0]  avm_address,
  output logic        avm_cs_hours,
  output logic        avm_cs_minutes,
  output logic        avm_write_n,
  output logic [31:0] avm_writedata,
  input  logic        avm_waitrequest
);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WR_HOURS   = 2'd1,
    WR_MINUTES = 2'd2
  } state_t;

  // Seven-segment code for one digit, bit 6 = g down to bit 0 = a.
  // Non-decimal inputs blank the digit; they cannot occur from valid time.
  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] code;
    case (d)
      4'd0:    code = 7'h40;
      4'd1:    code = 7'h79;
      4'd2:    code = 7'h24;
      4'd3:    code = 7'h30;
      4'd4:    code = 7'h19;
      4'd5:    code = 7'h12;
      4'd6:    code = 7'h02;
      4'd7:    code = 7'h78;
      4'd8:    code = 7'h00;
      4'd9:    code = 7'h10;
      default: code = 7'h7F;
    endcase
    return SEG_ACTIVE_LOW ? code : ~code;
  endfunction

  // Tens digit in [13:7], units digit in [6:0].
  function automatic logic [13:0] seg_pair(input logic [7:0] bcd);
    return {seg7(bcd[7:4]), seg7(bcd[3:0])};
  endfunction

  function automatic logic digits_ok(input logic [7:0] bcd);
    return (bcd[7:4] <= 4'd9) && (bcd[3:0] <= 4'd9);
  endfunction

  // BCD minute increment, 59 wraps to 00.
  function automatic logic [7:0] minute_inc(input logic [7:0] m);
    logic [7:0] r;
    if (m[3:0] == 4'd9) begin
      r = (m[7:4] == 4'd5) ? 8'h00 : {m[7:4] + 4'd1, 4'd0};
    end else begin
      r = {m[7:4], m[3:0] + 4'd1};
    end
    return r;
  endfunction

  // BCD hour increment, 23 wraps to 00.
  function automatic logic [7:0] hour_inc(input logic [7:0] h);
    logic [7:0] r;
    if (h == 8'h23) begin
      r = 8'h00;
    end else if (h[3:0] == 4'd9) begin
      r = {h[7:4] + 4'd1, 4'd0};
    end else begin
      r = {h[7:4], h[3:0] + 4'd1};
    end
    return r;
  endfunction

  logic [7:0] hours_q, minutes_q;
  logic [5:0] seconds_q;
  logic [7:0] hours_n, minutes_n;
  logic [5:0] seconds_n;
  logic       load_ok;
  logic       hm_change;
  logic       dirty_q;
  state_t     state_q, state_n;
  logic       snap_en;
  logic [7:0] snap_hours, snap_minutes;

  // Load validity: every digit decimal and value within a 24h clock.
  // BCD compares as plain binary once the digits are known to be decimal.
  assign load_ok = digits_ok(load_hours) && digits_ok(load_minutes) &&
                   (load_hours <= 8'h23) && (load_minutes <= 8'h59);

  // Next time value; a valid load wins over a tick in the same cycle.
  always_comb begin
    hours_n   = hours_q;
    minutes_n = minutes_q;
    seconds_n = seconds_q;
    hm_change = 1'b0;
    if (load && load_ok) begin
      hours_n   = load_hours;
      minutes_n = load_minutes;
      seconds_n = 6'd0;
      hm_change = 1'b1;
    end else if (tick_1hz) begin
      if (seconds_q == 6'd59) begin
        seconds_n = 6'd0;
        minutes_n = minute_inc(minutes_q);
        hm_change = 1'b1;
        if (minutes_q == 8'h59) begin
          hours_n = hour_inc(hours_q);
        end
      end else begin
        seconds_n = seconds_q + 6'd1;
      end
    end
  end

  // Time-of-day registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hours_q   <= 8'h00;
      minutes_q <= 8'h00;
      seconds_q <= 6'd0;
    end else begin
      hours_q   <= hours_n;
      minutes_q <= minutes_n;
      seconds_q <= seconds_n;
    end
  end

  // Display-stale flag: a change always wins over the clear taken when IDLE
  // snapshots, so an update arriving on that same edge is not lost.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dirty_q <= 1'b1;
    end else if (hm_change) begin
      dirty_q <= 1'b1;
    end else if (state_q == IDLE) begin
      dirty_q <= 1'b0;
    end
  end

  // Write-sequencer state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Snapshot of the pair being written; only read outside IDLE, so no reset.
  always_ff @(posedge clk) begin
    if (snap_en) begin
      snap_hours   <= hours_q;
      snap_minutes <= minutes_q;
    end
  end

  // Next state and bus outputs, decoded from registers only.
  always_comb begin
    state_n        = state_q;
    snap_en        = 1'b0;
    avm_address    = 2'd0;
    avm_cs_hours   = 1'b0;
    avm_cs_minutes = 1'b0;
    avm_write_n    = 1'b1;
    avm_writedata  = 32'd0;
    case (state_q)
      IDLE: begin
        if (dirty_q) begin
          snap_en = 1'b1;
          state_n = WR_HOURS;
        end
      end
      WR_HOURS: begin
        avm_cs_hours  = 1'b1;
        avm_write_n   = 1'b0;
        avm_writedata = {18'd0, seg_pair(snap_hours)};
        if (!avm_waitrequest) begin
          state_n = WR_MINUTES;
        end
      end
      WR_MINUTES: begin
        avm_cs_minutes = 1'b1;
        avm_write_n    = 1'b0;
        avm_writedata  = {18'd0, seg_pair(snap_minutes)};
        if (!avm_waitrequest) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign busy         = dirty_q | (state_q != IDLE);
  assign time_hours   = hours_q;
  assign time_minutes = minutes_q;
  assign time_seconds = seconds_q;

endmodule
